hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the 5-stage RV32 core. It generates `stall` and `id_flush`, which make the ID-stage control mux inject a bubble (zeroed WB/M/EX control) into ID/EX. It also generates the PC, IF/ID, ID/EX and EX/MEM write enables, the IF/ID flush and the EX/MEM bubble. It covers load-use hazards, EX-stage redirects (taken branch, JAL, JALR), data-memory wait states and multi-cycle EX operations.

---
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_CNT_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_use_rs1,
  input  logic                  ifid_use_rs2,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  ex_redirect,
  input  logic                  ex_mc_start,
  input  logic [MC_CNT_W-1:0]   ex_mc_cycles,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  if_flush,
  output logic                  stall,
  output logic                  id_flush,
  output logic                  idex_write,
  output logic                  exmem_write,
  output logic                  exmem_bubble
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN,
    S_MC,
    S_MW
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  state_t              w_eff;
  logic [MC_CNT_W-1:0] r_cnt;
  logic [MC_CNT_W-1:0] w_cnt_nx;
  logic                r_ret;
  logic                w_ret_nx;
  logic                w_lu;
  logic                w_rs1_hit;
  logic                w_rs2_hit;

  assign w_rs1_hit = ifid_use_rs1 && (ifid_rs1 == idex_rd);
  assign w_rs2_hit = ifid_use_rs2 && (ifid_rs2 == idex_rd);
  assign w_lu = idex_mem_read && (idex_rd != '0)
             && (w_rs1_hit || w_rs2_hit);

  // Leaving MEM_WAIT behaves as the state it returns to, same cycle.
  always_comb begin
    w_eff = r_state;
    if (r_state == S_MW && !mem_busy)
      w_eff = r_ret ? S_MC : S_RUN;
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    if_flush     = 1'b0;
    stall        = 1'b0;
    id_flush     = 1'b0;
    exmem_bubble = 1'b0;
    w_state_nx   = w_eff;
    w_cnt_nx     = r_cnt;
    w_ret_nx     = r_ret;
    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      if_flush     = 1'b1;
      id_flush     = 1'b1;
      exmem_bubble = 1'b1;
      w_state_nx   = S_RUN;
      w_cnt_nx     = '0;
      w_ret_nx     = 1'b0;
    end else begin
      unique case (w_eff)
        S_RUN: begin
          if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            w_state_nx  = S_MW;
            w_ret_nx    = 1'b0;
          end else if (ex_redirect) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
          end else if (ex_mc_start
                       && ex_mc_cycles >= MC_CNT_W'(2)) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            w_cnt_nx     = ex_mc_cycles - MC_CNT_W'(1);
            w_state_nx   = S_MC;
          end else if (w_lu) begin
            stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
          end
        end
        S_MC: begin
          if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            w_state_nx  = S_MW;
            w_ret_nx    = 1'b1;
          end else begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            w_cnt_nx   = r_cnt - MC_CNT_W'(1);
            if (r_cnt == MC_CNT_W'(1)) begin
              w_state_nx = S_RUN;
            end else begin
              exmem_bubble = 1'b1;
            end
          end
        end
        S_MW: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
        end
        default: begin
          w_state_nx = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_ret   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ret   <= w_ret_nx;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_write && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (if_flush && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule
